// File: rtl/neuron_ctrl_pkg.sv
// Shared types and defaults for the neuron sequencing controller.
package neuron_ctrl_pkg;
  localparam int NUM_CHUNKS_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int CHUNK_W = 64;
  localparam int LANES = 8;
  localparam int LANE_W = CHUNK_W / LANES;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;
endpackage

// File: rtl/neuron_chunk_counter.sv
// Chunk index counter with synchronous clear, increment and terminal-count flag.
module neuron_chunk_counter
  import neuron_ctrl_pkg::*;
#(
  parameter int NUM_CHUNKS = NUM_CHUNKS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

  assign tc = (count == ADDR_W'(NUM_CHUNKS - 1));
endmodule

// File: rtl/neuron_controller.sv
// Sequencer for one neuron datapath: clear, fetch NUM_CHUNKS chunks, then done.
// Define NEURON_CTRL_OUT_REG_EN to register the result in a CAPTURE state.
module neuron_controller
  import neuron_ctrl_pkg::*;
#(
  parameter int NUM_CHUNKS = NUM_CHUNKS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result,
  output logic              chunk_rd,
  output logic [ADDR_W-1:0] chunk_addr,
  input  logic              chunk_vld,
  output logic              dp_clr,
  output logic              dp_ld,
  input  logic [7:0]        dp_out,
  output state_t            state
);
  logic last;
  logic cnt_clr;
  logic cnt_inc;

  // Memory handshake: chunk_rd is a one-cycle request; the response is the
  // first chunk_vld seen in WAIT, which fires dp_ld in that same cycle.
  assign dp_ld   = (state == ST_WAIT) && chunk_vld;
  assign cnt_clr = (state == ST_CLEAR);
  assign cnt_inc = dp_ld && !last;

  neuron_chunk_counter #(
    .NUM_CHUNKS(NUM_CHUNKS),
    .ADDR_W    (ADDR_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .count(chunk_addr),
    .tc   (last)
  );

`ifdef NEURON_CTRL_OUT_REG_EN
  logic [7:0] result_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      chunk_rd <= 1'b0;
      dp_clr   <= 1'b0;
`ifdef NEURON_CTRL_OUT_REG_EN
      result_q <= '0;
`endif
    end else begin
      done     <= 1'b0;
      chunk_rd <= 1'b0;
      dp_clr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_CLEAR;
            busy   <= 1'b1;
            dp_clr <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state    <= ST_REQ;
          chunk_rd <= 1'b1;
        end
        ST_REQ: state <= ST_WAIT;
        ST_WAIT: begin
          if (chunk_vld) begin
            if (last) begin
`ifdef NEURON_CTRL_OUT_REG_EN
              state <= ST_CAPTURE;
`else
              state <= ST_DONE;
              done  <= 1'b1;
`endif
            end else begin
              state    <= ST_REQ;
              chunk_rd <= 1'b1;
            end
          end
        end
`ifdef NEURON_CTRL_OUT_REG_EN
        ST_CAPTURE: begin
          result_q <= dp_out;
          state    <= ST_DONE;
          done     <= 1'b1;
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NEURON_CTRL_OUT_REG_EN
  assign result = result_q;
`else
  // Unregistered result is only meaningful in the done cycle.
  assign result = done ? dp_out : 8'd0;
`endif
endmodule

// File: tb/tb_neuron_controller.sv
// Bench for neuron_controller: behavioural memory and datapath, event-schedule model.
module tb_neuron_controller;
  localparam int N = 8;
  localparam int AW = 3;
`ifdef NEURON_CTRL_OUT_REG_EN
  localparam int CAP = 1;
`else
  localparam int CAP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic chunk_vld = 1'b0;
  logic [7:0] dp_out;
  logic busy, done, chunk_rd, dp_clr, dp_ld;
  logic [7:0] result;
  logic [AW-1:0] chunk_addr;
  logic [2:0] state;

  neuron_controller #(.NUM_CHUNKS(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .result(result), .chunk_rd(chunk_rd), .chunk_addr(chunk_addr),
    .chunk_vld(chunk_vld), .dp_clr(dp_clr), .dp_ld(dp_ld),
    .dp_out(dp_out), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- memory and datapath environment ----------------
  logic [7:0] mem_w [N][8];
  logic [7:0] mem_i [N][8];
  logic [7:0] w_bus [8];
  logic [7:0] i_bus [8];
  int lat [N];
  bit spur_en = 1'b0;
  int pend = 0;
  int pend_addr = 0;

  function automatic int sm_prod(input logic [7:0] a, input logic [7:0] b);
    int m;
    m = int'(a[6:0]) * int'(b[6:0]);
    return (a[7] ^ b[7]) ? -m : m;
  endfunction

  function automatic logic [7:0] act_fn(input int v);
    if (v <= 0) return 8'd0;
    if ((v >>> 13) > 127) return 8'd127;
    return 8'(v >>> 13);
  endfunction

  function automatic int bus_sum();
    int s = 0;
    for (int l = 0; l < 8; l++) s += sm_prod(w_bus[l], i_bus[l]);
    return s;
  endfunction

  function automatic int golden();
    int s = 0;
    for (int c = 0; c < N; c++)
      for (int l = 0; l < 8; l++) s += sm_prod(mem_w[c][l], mem_i[c][l]);
    return s;
  endfunction

  always @(negedge clk) begin
    chunk_vld = 1'b0;
    if (!rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          chunk_vld = 1'b1;
          for (int l = 0; l < 8; l++) begin
            w_bus[l] = mem_w[pend_addr][l];
            i_bus[l] = mem_i[pend_addr][l];
          end
        end
      end
      if (chunk_rd) begin
        pend = lat[chunk_addr];
        pend_addr = int'(chunk_addr);
      end
      if (spur_en && !chunk_vld && (chunk_rd || dp_clr || done || !busy)) chunk_vld = 1'b1;
    end
  end

  int acc = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) acc <= 0;
    else if (dp_clr) acc <= 0;
    else if (dp_ld) acc <= acc + bus_sum();
  end
  assign dp_out = act_fn(acc);

  // ---------------- scoreboard ----------------
  logic [31:0] exp_clr_q[$], exp_rd_q[$], exp_addr_q[$], exp_ld_q[$], exp_done_q[$], exp_res_q[$];
  logic [31:0] act_clr_q[$], act_rd_q[$], act_addr_q[$], act_ld_q[$], act_done_q[$], act_res_q[$];

  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (dp_clr) act_clr_q.push_back(cyc);
      if (chunk_rd) begin
        act_rd_q.push_back(cyc);
        act_addr_q.push_back(32'(chunk_addr));
      end
      if (dp_ld) act_ld_q.push_back(cyc);
      if (done) begin
        act_done_q.push_back(cyc);
        act_res_q.push_back(32'(result));
      end
    end
  end

  // Event schedule from the timing rules: rd, then vld lat cycles later, next rd after that.
  task automatic model_req(input int t0, output int t_done);
    int t;
    exp_clr_q.push_back(t0 + 1);
    t = t0 + 2;
    for (int k = 0; k < N; k++) begin
      exp_rd_q.push_back(t);
      exp_addr_q.push_back(k);
      exp_ld_q.push_back(t + lat[k]);
      t = t + lat[k] + 1;
    end
    t_done = t + CAP;
    exp_done_q.push_back(t_done);
    exp_res_q.push_back(32'(act_fn(golden())));
  endtask

  task automatic cmp_q(input string tag, input logic [31:0] e[$], input logic [31:0] a[$]);
    check({tag, "_count"}, a.size(), e.size());
    for (int i = 0; i < e.size() && i < a.size(); i++)
      check($sformatf("%s[%0d]", tag, i), a[i], e[i]);
  endtask

  task automatic clear_logs();
    exp_clr_q.delete(); exp_rd_q.delete(); exp_addr_q.delete();
    exp_ld_q.delete(); exp_done_q.delete(); exp_res_q.delete();
    act_clr_q.delete(); act_rd_q.delete(); act_addr_q.delete();
    act_ld_q.delete(); act_done_q.delete(); act_res_q.delete();
  endtask

  task automatic scoreboard(input string tag);
    cmp_q({tag, "_clr"}, exp_clr_q, act_clr_q);
    cmp_q({tag, "_rd"}, exp_rd_q, act_rd_q);
    cmp_q({tag, "_addr"}, exp_addr_q, act_addr_q);
    cmp_q({tag, "_ld"}, exp_ld_q, act_ld_q);
    cmp_q({tag, "_done"}, exp_done_q, act_done_q);
    cmp_q({tag, "_res"}, exp_res_q, act_res_q);
    clear_logs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill(input bit rand_lat, input bit rand_data);
    for (int c = 0; c < N; c++) begin
      lat[c] = rand_lat ? int'($urandom_range(1, 4)) : 1;
      for (int l = 0; l < 8; l++) begin
        mem_w[c][l] = rand_data ? 8'($urandom_range(0, 255)) : 8'h7f;
        mem_i[c][l] = rand_data ? 8'($urandom_range(0, 255)) : 8'h7f;
      end
    end
  endtask

  task automatic wait_done(input int n, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (act_done_q.size() >= n) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_req(input bit hold, input int nreq, input int exp_done_lat, input string tag);
    int t0, td, tfirst, dfirst;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    tfirst = t0;
    for (int r = 0; r < nreq; r++) begin
      model_req(t0, td);
      t0 = td + 1;
    end
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(nreq, tag);
    start = 1'b0;
    if (exp_done_lat >= 0) begin
      dfirst = (act_done_q.size() > 0) ? int'(act_done_q[0]) : -1;
      check({tag, "_done_cycle"}, dfirst - tfirst, exp_done_lat);
    end
    repeat (3) @(negedge clk);
    #2;
    scoreboard(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_ok;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_rd", chunk_rd, 0);
    check("rst_addr", chunk_addr, 0);
    check("rst_clr", dp_clr, 0);
    check("rst_ld", dp_ld, 0);
    check("rst_state", state, 0);
    rst = 1'b1;

    fill(1'b0, 1'b1);
    run_req(1'b0, 1, 2 * N + 2 + CAP, "basic");

    fill(1'b0, 1'b1);
    lat[2] = 4;
    run_req(1'b0, 1, 2 * N + 5 + CAP, "slow_chunk2");

    fill(1'b1, 1'b1);
    run_req(1'b1, 2, -1, "start_held");

    fill(1'b1, 1'b1);
    spur_en = 1'b1;
    repeat (4) @(negedge clk);
    run_req(1'b0, 1, -1, "spurious");
    spur_en = 1'b0;

    // Reset while waiting on chunk 4.
    fill(1'b0, 1'b1);
    lat[4] = 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_ok = 0;
    for (int i = 0; i < 100 && t_ok == 0; i++) begin
      @(negedge clk);
      #2;
      if (chunk_rd && chunk_addr == AW'(4)) t_ok = 1;
    end
    check("rstmid_reach_addr4", t_ok, 1);
    @(negedge clk);
    #2;
    check("rstmid_pre_addr", chunk_addr, 4);
    rst = 1'b0;
    chunk_vld = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_result", result, 0);
    check("rstmid_rd", chunk_rd, 0);
    check("rstmid_addr", chunk_addr, 0);
    check("rstmid_clr", dp_clr, 0);
    check("rstmid_ld", dp_ld, 0);
    repeat (2) @(negedge clk);
    check("rstmid_no_done", act_done_q.size(), 0);
    rst = 1'b1;
    clear_logs();
    fill(1'b0, 1'b1);
    run_req(1'b0, 1, 2 * N + 2 + CAP, "after_rst");

    // Saturating-magnitude datapath case: every byte 0x7F.
    fill(1'b0, 1'b0);
    check("golden_7f", 32'(act_fn(golden())), 126);
    run_req(1'b0, 1, 2 * N + 2 + CAP, "all_7f");
    check("result_after_done", result, CAP ? 126 : 0);

    for (int r = 0; r < 6; r++) begin
      fill(1'b1, 1'b1);
      run_req(1'b0, 1, -1, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/neuron_controller.md
# neuron_controller

Sequencing controller for one neuron datapath (8 signed-magnitude products per cycle into a 21-bit accumulator, then bias, saturation and activation). For each request it clears the accumulator, fetches NUM_CHUNKS weight/input chunks of 64 bits each from the neuron's storage through a read/valid handshake, and pulses the datapath load once per returned chunk. It then presents the 8-bit activation result with a one-cycle done pulse. It sits between the layer scheduler (start/done) and the neuron datapath plus its weight/input memory.

## Interface
- NUM_CHUNKS, 8: number of 8-input chunks per neuron (64 inputs by default); must be ≥ 1
- ADDR_W, 3: chunk address width; must be ≥ 1 and satisfy 2^ADDR_W ≥ NUM_CHUNKS

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result is valid in this cycle
- result  out  8  neuron output
- chunk_rd  out  1  one-cycle read strobe to weight/input memory
- chunk_addr  out  ADDR_W  chunk index being fetched
- chunk_vld  in  1  memory data on the datapath w/inp buses is valid this cycle
- dp_clr  out  1  active-high accumulator clear, driven to the datapath register reset
- dp_ld  out  1  accumulator load enable to the datapath
- dp_out  in  8  datapath activation output

## Operation
- FSM states: IDLE, CLEAR, REQ, WAIT, CAPTURE (only when the output register is compiled in), DONE.
- IDLE: when start=1, go to CLEAR. start received while busy=1 is ignored and is not queued.
- CLEAR: dp_clr=1 for exactly one cycle. The chunk counter loads 0. Next state is REQ.
- REQ: chunk_rd=1 for one cycle with chunk_addr equal to the counter. Next state is WAIT.
- WAIT: the FSM holds until chunk_vld=1. In the chunk_vld cycle, dp_ld=1 combinationally. In that cycle:
  - if counter = NUM_CHUNKS-1, go to CAPTURE (or DONE without the macro);
  - otherwise increment the counter and go to REQ.
- chunk_vld is ignored in every state except WAIT.
- DONE: done=1 for one cycle, then go to IDLE. A start in the DONE cycle is ignored; start must still be high in IDLE to be accepted.
- chunk_addr holds its last value between reads. It is 0 after reset and after CLEAR.
- dp_ld is never asserted without a preceding chunk_rd. The number of dp_ld pulses per request is exactly NUM_CHUNKS.
- The controller performs no arithmetic on data. Accumulation width, bias and saturation belong to the datapath.

## Timing
- Reset values: busy=0, done=0, result=0, chunk_rd=0, chunk_addr=0, dp_clr=0, dp_ld=0; state is IDLE.
- Cycle numbering: cycle 0 is the IDLE cycle in which start=1 is sampled.
  - Cycle 1: CLEAR.
  - Chunk k: REQ in cycle 2+2k, WAIT in cycle 3+2k. This assumes one-cycle memory latency, where chunk_vld arrives in the cycle after chunk_rd.
- Each extra cycle of memory latency adds one WAIT cycle per chunk.
- With the output register compiled out, done rises in cycle 2·NUM_CHUNKS+2 (cycle 18 for the defaults). With it compiled in, done rises one cycle later.
- Asynchronous reset mid-operation forces IDLE and all reset values immediately. No partial done is issued. An in-flight chunk_vld is ignored.

## Configuration
- NEURON_CTRL_OUT_REG_EN defined:
  - CAPTURE state exists; result is a register loaded from dp_out in CAPTURE;
  - result holds until the next capture or reset;
  - done is asserted one cycle after CAPTURE.
- Undefined:
  - no CAPTURE state;
  - result = dp_out while done=1, and 0 otherwise;
  - the caller must sample result in the done cycle.

## Structure
- Shared package neuron_ctrl_pkg holds:
  - the state enumeration and its encoding;
  - the NUM_CHUNKS/ADDR_W defaults;
  - the chunk bit width constant (64) and the lane count (8).
- One sub-module, neuron_chunk_counter: an ADDR_W counter with clear, increment and a terminal-count flag (count = NUM_CHUNKS-1).

## Test plan
- Defaults, memory with 1-cycle latency, start pulse in cycle 0:
  - dp_clr in cycle 1;
  - chunk_rd in cycles 2,4,…,16 with addr 0..7;
  - 8 dp_ld pulses;
  - done in cycle 18 (19 with NEURON_CTRL_OUT_REG_EN).
- chunk_vld for chunk 2 delayed by 3 extra cycles -> done 3 cycles later (21 without macro); dp_ld count remains 8.
- start held high through a whole request -> exactly one CLEAR per acceptance; the second request begins with CLEAR in the cycle after re-entering IDLE.
- Spurious chunk_vld in IDLE and REQ -> no dp_ld.
- rst asserted in WAIT with chunk_addr=4 -> all outputs 0 immediately. The next start restarts from addr 0 with dp_clr.
- Full datapath: all weight and input bytes 0x7F, bias 0 -> result matches the datapath golden model. With the macro, result is held after done until the next capture.
